// File: rtl/face_match_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | face_match_pkg : shared types and fp32 ordering helpers for best-match     |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package face_match_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_EMIT_IDX   = 2'd1,
    ST_EMIT_SCORE = 2'd2
  } state_t;

  localparam logic [7:0] FP32_NAN_EXP = 8'hFF;

  // Maps fp32 bit patterns onto an unsigned total order with -0 below +0.
  function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_NAN_EXP) && (x[22:0] != 23'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_max_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp32_max_cmp : decides whether a candidate score displaces the best score  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module fp32_max_cmp
  import face_match_pkg::*;
(
  input  logic [31:0] i_cand,
  input  logic [31:0] i_best,
  output logic        o_replace
);

  logic w_cand_nan;
  logic w_best_nan;
  logic w_greater;

  assign w_cand_nan = fp32_is_nan(i_cand);
  assign w_best_nan = fp32_is_nan(i_best);
  assign w_greater  = fp32_order_key(i_cand) > fp32_order_key(i_best);

  // A stored NaN only survives until the first real score arrives.
  assign o_replace = !w_cand_nan && (w_best_nan || w_greater);

endmodule
`default_nettype wire

// File: rtl/best_match_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | best_match_tracker : streaming fp32 arg-max, emits index then score        |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module best_match_tracker
  import face_match_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             bus_clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] gallery_size,
  input  logic             in_wren,
  input  logic [31:0]      in_data,
  output logic             in_full,
  output logic             out_wren,
  output logic [31:0]      out_data,
  input  logic             out_full,
  output logic             busy
);

  localparam logic [IDX_W-1:0] c_one = IDX_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_size;
  logic [31:0]      r_best_score;
  logic [IDX_W-1:0] r_best_idx;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_replace;
  logic [IDX_W-1:0] w_size_in;
  logic [IDX_W-1:0] w_size_eff;

  assign w_accept   = in_wren && (r_state == ST_COLLECT);
  assign w_first    = (r_cnt == '0);
  assign w_size_in  = (gallery_size == '0) ? c_one : gallery_size;
  // The live port only matters on the first score; later scores use the latch.
  assign w_size_eff = w_first ? w_size_in : r_size;
  assign w_last     = (r_cnt == (w_size_eff - c_one));

  fp32_max_cmp u_cmp (
    .i_cand    (in_data),
    .i_best    (r_best_score),
    .o_replace (w_replace)
  );

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    out_wren     = 1'b0;
    out_data     = 32'd0;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept && w_last) begin
          w_state_next = ST_EMIT_IDX;
        end
      end
      ST_EMIT_IDX: begin
        out_data = 32'(r_best_idx);
        out_wren = !out_full;
        if (!out_full) begin
          w_state_next = ST_EMIT_SCORE;
        end
      end
      ST_EMIT_SCORE: begin
        out_data = r_best_score;
        out_wren = !out_full;
        if (!out_full) begin
          w_state_next = ST_COLLECT;
        end
      end
      default: begin
        w_state_next = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_size       <= c_one;
      r_best_score <= 32'd0;
      r_best_idx   <= '0;
    end else if (w_accept) begin
      if (w_first) begin
        r_size       <= w_size_in;
        r_best_score <= in_data;
        r_best_idx   <= '0;
      end else if (w_replace) begin
        r_best_score <= in_data;
        r_best_idx   <= r_cnt;
      end
      r_cnt <= w_last ? '0 : (r_cnt + c_one);
    end
  end

  assign in_full = (r_state != ST_COLLECT);
  assign busy    = (r_state != ST_COLLECT) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_best_match_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_best_match_tracker : directed and randomized checks of the arg-max      |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_best_match_tracker;

  logic        bus_clk = 1'b0;
  logic        rst_n;
  logic [15:0] gallery_size;
  logic        in_wren;
  logic [31:0] in_data;
  logic        in_full;
  logic        out_wren;
  logic [31:0] out_data;
  logic        out_full;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 bus_clk = ~bus_clk;

  best_match_tracker #(.IDX_W(16)) dut (
    .bus_clk      (bus_clk),
    .rst_n        (rst_n),
    .gallery_size (gallery_size),
    .in_wren      (in_wren),
    .in_data      (in_data),
    .in_full      (in_full),
    .out_wren     (out_wren),
    .out_data     (out_data),
    .out_full     (out_full),
    .busy         (busy)
  );

  function automatic bit m_is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Sign-magnitude comparison: a strictly above b (both non-NaN).
  function automatic bit m_above(logic [31:0] a, logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  task automatic model(input logic [31:0] s[$], output int idx);
    idx = -1;
    for (int i = 0; i < s.size(); i++) begin
      if (!m_is_nan(s[i]) && (idx < 0 || m_above(s[i], s[idx]))) idx = i;
    end
    if (idx < 0) idx = 0;
  endtask

  function automatic logic [31:0] rnd_score();
    logic [31:0] r;
    logic [31:0] pool [4];
    pool[0] = 32'h3F800000; pool[1] = 32'hBF800000;
    pool[2] = 32'h40490FDB; pool[3] = 32'h00000001;
    r = $urandom;
    case ($urandom % 8)
      0: return {r[31], 8'hFF, r[22:0] | 23'd1};
      1: return {r[31], 31'd0};
      2: return {r[31], 8'hFF, 23'd0};
      3, 4: return pool[$urandom % 4];
      default: return r;
    endcase
  endfunction

  task automatic send_block(input logic [31:0] s[$], input int gap_max, input bit vary_size);
    for (int i = 0; i < s.size(); i++) begin
      if (gap_max > 0) begin
        in_wren = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge bus_clk);
      end
      in_wren = 1'b1;
      in_data = s[i];
      @(negedge bus_clk);
      if (vary_size) gallery_size = 16'($urandom);
    end
    in_wren = 1'b0;
  endtask

  task automatic collect(output logic [31:0] w0, output logic [31:0] w1,
                         output bit ok, input bit rand_full);
    int got = 0;
    w0 = 32'hDEAD_DEAD;
    w1 = 32'hDEAD_DEAD;
    for (int cyc = 0; cyc < 64 && got < 2; cyc++) begin
      out_full = rand_full ? (($urandom % 3) == 0) : 1'b0;
      #1;
      if (out_wren) begin
        if (got == 0) w0 = out_data; else w1 = out_data;
        got++;
      end
      @(negedge bus_clk);
    end
    out_full = 1'b0;
    ok = (got == 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_wren = 1'b0; in_data = 32'd0; out_full = 1'b0; gallery_size = 16'd4;
    repeat (3) @(negedge bus_clk);
    n_checks++;
    if ({out_wren, in_full, busy} !== 3'b000 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: wren/full/busy=%b data=%h required 000 / 00000000",
               {out_wren, in_full, busy}, out_data);
    end
    rst_n = 1'b1;
    @(negedge bus_clk);
  endtask

  task automatic test_basic_latency();
    logic [31:0] q[$];
    q = '{32'h3F000000, 32'h3F800000, 32'h3F666666, 32'hBF800000};
    gallery_size = 16'd4;
    send_block(q, 0, 0);
    #1;
    n_checks++;
    if (out_wren !== 1'b1 || out_data !== 32'h1) begin
      n_fail++;
      $display("FAIL basic_idx: wren=%b data=%h required 1 / 00000001", out_wren, out_data);
    end
    @(negedge bus_clk); #1;
    n_checks++;
    if (out_wren !== 1'b1 || out_data !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL basic_score: wren=%b data=%h required 1 / 3f800000", out_wren, out_data);
    end
    @(negedge bus_clk);
  endtask

  task automatic run_directed(input string name, input logic [15:0] sz,
                              input logic [31:0] q[$], input logic [31:0] exp_idx,
                              input logic [31:0] exp_score);
    logic [31:0] w0, w1;
    bit ok;
    gallery_size = sz;
    send_block(q, 0, 0);
    collect(w0, w1, ok, 0);
    n_checks++;
    if (!ok || w0 !== exp_idx || w1 !== exp_score) begin
      n_fail++;
      $display("FAIL %s: got idx=%h score=%h done=%0d required idx=%h score=%h",
               name, w0, w1, ok, exp_idx, exp_score);
    end
  endtask

  task automatic test_tie_and_nan();
    run_directed("tie_first", 16'd3, '{32'h3F800000, 32'h3F800000, 32'h3F000000},
                 32'd0, 32'h3F800000);
    run_directed("nan_displaced", 16'd3, '{32'h7FC00000, 32'hBF800000, 32'h80000000},
                 32'd2, 32'h80000000);
    run_directed("pos_over_neg_zero", 16'd2, '{32'h80000000, 32'h00000000},
                 32'd1, 32'h00000000);
  endtask

  task automatic test_backpressure();
    gallery_size = 16'd2;
    in_wren = 1'b1; in_data = 32'h40400000;
    @(negedge bus_clk);
    in_data = 32'hC0000000; out_full = 1'b1;
    @(negedge bus_clk);
    in_data = 32'h7F7FFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (out_wren !== 1'b0 || in_full !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: wren=%b in_full=%b required 0 / 1", i, out_wren, in_full);
      end
      @(negedge bus_clk);
    end
    in_wren = 1'b0; out_full = 1'b0;
    #1;
    n_checks++;
    if (out_wren !== 1'b1 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL resume_idx: wren=%b data=%h required 1 / 00000000", out_wren, out_data);
    end
    @(negedge bus_clk); #1;
    n_checks++;
    if (out_wren !== 1'b1 || out_data !== 32'h40400000) begin
      n_fail++;
      $display("FAIL resume_score: wren=%b data=%h required 1 / 40400000", out_wren, out_data);
    end
    @(negedge bus_clk); #1;
    n_checks++;
    if (busy !== 1'b0 || in_full !== 1'b0 || out_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL after_emit_idle: busy=%b in_full=%b wren=%b required 0 0 0",
               busy, in_full, out_wren);
    end
    @(negedge bus_clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    bit ok;
    gallery_size = 16'd0;
    for (int b = 0; b < 3; b++) begin
      send_block('{32'h40000000 + 32'(b)}, 0, 0);
      collect(w0, w1, ok, 0);
      n_checks++;
      if (!ok || w0 !== 32'd0 || w1 !== 32'h40000000 + 32'(b)) begin
        n_fail++;
        $display("FAIL b2b_%0d: idx=%h score=%h done=%0d required 00000000 / %h",
                 b, w0, w1, ok, 32'h40000000 + 32'(b));
      end
      n_checks++;
      if (in_full !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: in_full=%b required 0", b, in_full);
      end
    end
  endtask

  task automatic test_reset_midblock();
    logic [31:0] w0, w1;
    bit ok;
    bit seen = 0;
    gallery_size = 16'd4;
    send_block('{32'h41000000, 32'h42000000}, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midblock_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    @(negedge bus_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_wren) seen = 1;
      @(negedge bus_clk);
    end
    n_checks++;
    if (seen || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: wren_seen=%0d busy=%b required 0 / 0", seen, busy);
    end
    send_block('{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000}, 0, 0);
    collect(w0, w1, ok, 0);
    n_checks++;
    if (!ok || w0 !== 32'd3 || w1 !== 32'h40400000) begin
      n_fail++;
      $display("FAIL post_reset_block: idx=%h score=%h done=%0d required 00000003 / 40400000",
               w0, w1, ok);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] w0, w1;
    bit ok;
    int sz, n, idx;
    for (int b = 0; b < 40; b++) begin
      sz = $urandom_range(0, 9);
      n  = (sz == 0) ? 1 : sz;
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(rnd_score());
      model(q, idx);
      gallery_size = 16'(sz);
      send_block(q, 2, 1);
      collect(w0, w1, ok, 1);
      n_checks++;
      if (!ok || w0 !== 32'(idx) || w1 !== q[idx]) begin
        n_fail++;
        $display("FAIL random_%0d: size=%0d idx=%h score=%h done=%0d required %h / %h",
                 b, sz, w0, w1, ok, 32'(idx), q[idx]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_tie_and_nan();
    test_backpressure();
    test_back_to_back();
    test_reset_midblock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
